fifo_reader: RTL and testbench

- Autonomous drain engine for the consumer side of the 8-bit synchronous FIFO (`fifo`: buf_out / rd_en / buf_empty).
- Watches buf_empty, issues single-cycle rd_en pulses, and captures the word the FIFO presents on buf_out.
- Re-presents the words to a downstream consumer over a valid/ready interface.
- A 2-entry output buffer sustains one word per clock while absorbing downstream back-pressure; FIFO order is preserved.

---
 rtl/fifo_reader.sv | 106 ++++++++++
 tb/tb_fifo_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//
// Drain engine for the consumer side of an 8-bit synchronous FIFO. It watches
// buf_empty and issues single-cycle rd_en pulses. The word the FIFO presents on
// buf_out one cycle later is captured into a 2-entry output buffer. That buffer
// is offered downstream over a valid/ready handshake, in FIFO order.
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         asynchronous active-high reset
//   drain_en    1 = allowed to issue new FIFO reads
//   buf_out     FIFO read data (valid the cycle after an accepted rd_en)
//   buf_empty   FIFO empty flag
//   rd_en       FIFO pop request (combinational)
//   data_out    word at the head of the output buffer
//   valid_out   data_out holds a word
//   ready_in    downstream accepts data_out this cycle
//   words_read  number of words delivered downstream (wraps)
//
// Build option:
//   FIFO_READER_COUNT_EN  when defined, words_read is a real wrapping counter
//                         of delivered words; otherwise it is tied to zero and
//                         no counter flops exist.
// ---------------------------------------------------------------------------
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drain_en,
    input  logic [DATA_WIDTH-1:0] buf_out,
    input  logic                  buf_empty,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [CNT_WIDTH-1:0]  words_read
);

    logic [1:0]            occ;
    logic                  inflight;
    logic                  head;
    logic                  tail;
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  pop;
    logic [2:0]            pending;

    assign valid_out = (occ != 2'd0);
    assign data_out  = mem[head];
    assign pop       = valid_out & ready_in;

    // Words already committed to the buffer (stored or in flight) once this
    // cycle's pop is accounted for. A new read is only safe while that stays
    // below the buffer depth, so a capture can never land in a full buffer.
    // This makes rd_en depend combinationally on ready_in.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en   = drain_en & ~buf_empty & (pending < 3'd2);

    // Buffer state: the in-flight word is written at the tail the cycle after
    // rd_en, the head is released on a downstream pop, and both may happen in
    // the same cycle. Clearing the storage on reset also makes data_out 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            inflight <= rd_en;
            if (inflight) begin
                mem[tail] <= buf_out;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    // Delivered-word counter, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign words_read = count_q;
`else
    assign words_read = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_reader
//
// Bench for fifo_reader (CNT_WIDTH=4 so the counter wrap is reachable).
// Contains a behavioural FIFO and a reference model that tracks, at word level, every word
// read from the FIFO but not yet delivered, together with the cycle it was
// requested in. A word becomes visible downstream two cycles after its read,
// at most two words may be outstanding, and words leave in order.
// ---------------------------------------------------------------------------
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 4;
`ifdef FIFO_READER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          drain_en;
    logic [DW-1:0] buf_out = '0;
    logic          buf_empty;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic [CW-1:0] words_read;

    int total = 0;
    int bad   = 0;

    // Behavioural FIFO state
    logic [DW-1:0] fifo_q [$];
    int            fifo_level = 0;
    int            fifo_lvl_next;
    logic          push_valid;
    logic [DW-1:0] push_data;

    // Reference model state
    logic [DW-1:0] out_q [$];
    int            out_t [$];
    logic [DW-1:0] out_log [$];
    int            cyc = 0;
    int            delivered = 0;
    int            rd_pulses = 0;
    bit            m_valid;
    bit            m_pop;
    bit            m_rd;
    int            m_pending;

    typedef struct {
        logic          drain;
        logic          ready;
        logic          exp_rd;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } row_t;
    row_t tbl [11];

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .drain_en   (drain_en),
        .buf_out    (buf_out),
        .buf_empty  (buf_empty),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .words_read (words_read)
    );

    always #5 clk = ~clk;

    assign buf_empty = (fifo_level == 0);

    // FIFO: pops on an accepted rd_en, new word on buf_out after that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            fifo_level <= 0;
            buf_out    <= '0;
        end else begin
            fifo_lvl_next = fifo_level;
            if (rd_en && fifo_level > 0) begin
                buf_out <= fifo_q.pop_front();
                fifo_lvl_next = fifo_lvl_next - 1;
            end
            if (push_valid) begin
                fifo_q.push_back(push_data);
                fifo_lvl_next = fifo_lvl_next + 1;
            end
            fifo_level <= fifo_lvl_next;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic drain, input logic ready);
        drain_en = drain;
        ready_in = ready;
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        push_valid = 1'b1;
        push_data  = w;
        stepCycles(1);
        push_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        stepCycles(2);
        rst = 1'b0;
    endtask

    // Reference model, evaluated mid-cycle while all inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            out_q.delete();
            out_t.delete();
            cyc       = 0;
            delivered = 0;
            checkOutput("reset_valid_out", int'(valid_out), 0);
            checkOutput("reset_rd_en", int'(rd_en), 0);
            checkOutput("reset_words_read", int'(words_read), 0);
        end else begin
            m_valid = 1'b0;
            if (out_q.size() > 0) m_valid = (cyc - out_t[0] >= 2);
            m_pop     = m_valid && ready_in;
            m_pending = out_q.size() - (m_pop ? 1 : 0);
            m_rd      = drain_en && (fifo_level > 0) && (m_pending < 2);
            checkOutput("rd_en", int'(rd_en), int'(m_rd));
            checkOutput("valid_out", int'(valid_out), int'(m_valid));
            if (m_valid) checkOutput("data_out", int'(data_out), int'(out_q[0]));
            checkOutput("words_read", int'(words_read), COUNT_EN ? (delivered % 16) : 0);
            if (rd_en) rd_pulses++;
            if (m_pop) begin
                out_log.push_back(out_q.pop_front());
                void'(out_t.pop_front());
                delivered++;
            end
            if (m_rd) begin
                out_q.push_back(fifo_q[0]);
                out_t.push_back(cyc);
            end
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p0;
        int n0;
        int found;

        // Back-pressure vectors: 4 words queued, stall 6 cycles, then release.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd10};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd10};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd10};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd10};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd10};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd20};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd30};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd40};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        applyStimulus(1'b0, 1'b0);
        stepCycles(2);
        checkOutput("init_valid_out", int'(valid_out), 0);
        checkOutput("init_data_out", int'(data_out), 0);
        checkOutput("init_words_read", int'(words_read), 0);
        rst = 1'b0;
        stepCycles(1);

        // Single word
        applyStimulus(1'b1, 1'b1);
        p0 = rd_pulses;
        pushWord(8'd1);
        stepCycles(6);
        checkOutput("single_rd_pulses", rd_pulses - p0, 1);
        checkOutput("single_delivered_count", out_log.size(), 1);
        if (out_log.size() == 1) checkOutput("single_word", int'(out_log[0]), 1);
        checkOutput("single_words_read", int'(words_read), COUNT_EN ? 1 : 0);

        // Streaming 10..80
        applyStimulus(1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) pushWord(DW'(i * 10));
        p0 = rd_pulses;
        n0 = out_log.size();
        applyStimulus(1'b1, 1'b1);
        stepCycles(12);
        checkOutput("stream_rd_pulses", rd_pulses - p0, 8);
        checkOutput("stream_delivered", out_log.size() - n0, 8);
        if (out_log.size() - n0 == 8)
            for (int i = 0; i < 8; i++) checkOutput("stream_order", int'(out_log[n0 + i]), (i + 1) * 10);
        checkOutput("stream_words_read", int'(words_read), COUNT_EN ? 9 : 0);

        // Empty then refill, with toggling ready
        p0 = rd_pulses;
        stepCycles(4);
        checkOutput("empty_no_rd", rd_pulses - p0, 0);
        n0 = out_log.size();
        pushWord(8'd140);
        stepCycles(4);
        push_valid = 1'b1;
        push_data  = 8'd5;
        for (int i = 0; i < 8; i++) begin
            ready_in = ~ready_in;
            stepCycles(1);
            push_valid = 1'b0;
        end
        applyStimulus(1'b1, 1'b1);
        stepCycles(3);
        checkOutput("refill_delivered", out_log.size() - n0, 2);
        if (out_log.size() - n0 == 2) begin
            checkOutput("refill_first", int'(out_log[n0]), 140);
            checkOutput("refill_second", int'(out_log[n0 + 1]), 5);
        end

        // Back-pressure table
        doReset();
        applyStimulus(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) pushWord(DW'(i * 10));
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].drain, tbl[i].ready);
            @(negedge clk);
            #1;
            checkOutput($sformatf("bp_rd_en[%0d]", i), int'(rd_en), int'(tbl[i].exp_rd));
            checkOutput($sformatf("bp_valid[%0d]", i), int'(valid_out), int'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                checkOutput($sformatf("bp_data[%0d]", i), int'(data_out), int'(tbl[i].exp_data));
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ready_in = ($urandom_range(3) != 0);
            drain_en = ($urandom_range(7) != 0);
            if ($urandom_range(1) == 1 && fifo_level < 12) begin
                push_valid = 1'b1;
                push_data  = DW'($urandom_range(255));
            end else begin
                push_valid = 1'b0;
            end
            stepCycles(1);
        end
        push_valid = 1'b0;
        applyStimulus(1'b1, 1'b1);
        stepCycles(30);

        // Reset mid-stream with one word buffered and one in flight
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pushWord(DW'(100 + i));
        drain_en = 1'b1;
        stepCycles(2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid_out", int'(valid_out), 0);
        checkOutput("midrst_rd_en", int'(rd_en), 0);
        checkOutput("midrst_words_read", int'(words_read), 0);
        stepCycles(2);
        rst = 1'b0;
        ready_in   = 1'b1;
        push_valid = 1'b1;
        push_data  = 8'd200;
        stepCycles(1);
        push_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (rd_en) found = 1;
        end
        checkOutput("midrst_first_rd_seen", found, 1);
        if (found == 1) begin
            @(negedge clk);
            checkOutput("midrst_valid_n1", int'(valid_out), 0);
            @(negedge clk);
            checkOutput("midrst_valid_n2", int'(valid_out), 1);
            checkOutput("midrst_data_n2", int'(data_out), 200);
        end
        @(posedge clk);
        #1;
        stepCycles(4);

        // Counter wrap: 17 words with CNT_WIDTH=4
        doReset();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 17; i++) pushWord(DW'(i + 1));
        stepCycles(6);
        checkOutput("wrap_words_read", int'(words_read), COUNT_EN ? 1 : 0);
        checkOutput("wrap_delivered", delivered, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
